// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and header field positions for the router write side
package router_pkg;

    localparam int NUM_PORTS    = 3;
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_LEN_MSB  = 7;

    localparam logic [1:0] ADDR_DROP = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        PARITY  = 2'd2
    } wr_state_t;

endpackage

// File: rtl/router_wr_hold_reg.sv
// rtl/router_wr_hold_reg.sv - single-entry hold stage between the source and the three FIFOs
module router_wr_hold_reg #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PORTS  = 3
) (
    input  logic                  write_clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [1:0]            i_dest,
    input  logic                  i_drop,
    input  logic [NUM_PORTS-1:0]  i_fifo_full,
    output logic                  o_ready,
    output logic                  o_wr_fire,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic [NUM_PORTS-1:0]  o_write_inc
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_dest;
    logic                  r_drop;
    logic [NUM_PORTS-1:0]  w_dest_oh;

    // Decoding to one-hot keeps the out-of-range drop address from indexing fifo_full.
    always_comb begin
        w_dest_oh = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_dest_oh[p] = (r_dest == 2'(p));
        end
    end

    assign o_wr_fire   = r_valid && !r_drop && ((w_dest_oh & i_fifo_full) == '0);
    assign o_ready     = !r_valid || o_wr_fire;
    assign o_write_inc = o_wr_fire ? w_dest_oh : '0;
    assign o_wr_data   = r_data;

    always_ff @(posedge write_clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_dest  <= '0;
            r_drop  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_dest  <= i_dest;
            r_drop  <= i_drop;
        end else if (o_wr_fire || r_drop) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/router_fifo_writer.sv
// rtl/router_fifo_writer.sv - write-side packet engine of the 1x3 router
// Optional statistics counters are enabled by defining ROUTER_WR_STATS_EN.
module router_fifo_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PORTS  = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  write_clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_PORTS-1:0]  fifo_full,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic [NUM_PORTS-1:0]  fifo_write_inc,
`ifdef ROUTER_WR_STATS_EN
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
`endif
    output logic                  pkt_done,
    output logic                  parity_err,
    output logic                  pkt_drop
);

    import router_pkg::*;

    wr_state_t             r_state;
    wr_state_t             w_next_state;
    logic [5:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [1:0]            r_dest;
    logic                  r_drop;

    logic                  w_accept;
    logic                  w_wr_fire;
    logic [1:0]            w_hdr_dest;
    logic [5:0]            w_hdr_len;
    logic [1:0]            w_byte_dest;
    logic                  w_byte_drop;
    logic                  w_done_set;
    logic                  w_err_set;
    logic                  w_drop_set;

    assign w_accept   = in_valid && in_ready;
    assign w_hdr_dest = in_data[HDR_ADDR_MSB:HDR_ADDR_LSB];
    assign w_hdr_len  = in_data[HDR_LEN_MSB:HDR_LEN_LSB];

    always_ff @(posedge write_clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_accept) begin
            case (r_state)
                IDLE:    w_next_state = (w_hdr_len != 6'd0) ? PAYLOAD : PARITY;
                PAYLOAD: w_next_state = (r_cnt == 6'd1) ? PARITY : PAYLOAD;
                PARITY:  w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // The header byte itself carries the route, so it must not use the latched dest.
    always_comb begin
        w_byte_dest = r_dest;
        w_byte_drop = r_drop;
        if (r_state == IDLE) begin
            w_byte_dest = w_hdr_dest;
            w_byte_drop = (w_hdr_dest == ADDR_DROP);
        end
        w_done_set = w_accept && (r_state == PARITY);
        w_err_set  = w_done_set && (r_acc != in_data) && !r_drop;
        w_drop_set = w_accept && (r_state == IDLE) && (w_hdr_dest == ADDR_DROP);
    end

    always_ff @(posedge write_clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_dest     <= '0;
            r_drop     <= 1'b0;
            pkt_done   <= 1'b0;
            parity_err <= 1'b0;
            pkt_drop   <= 1'b0;
        end else begin
            pkt_done   <= w_done_set;
            parity_err <= w_err_set;
            pkt_drop   <= w_drop_set;
            if (w_accept) begin
                case (r_state)
                    IDLE: begin
                        r_dest <= w_hdr_dest;
                        r_drop <= (w_hdr_dest == ADDR_DROP);
                        r_acc  <= in_data;
                        r_cnt  <= w_hdr_len;
                    end
                    PAYLOAD: begin
                        r_acc <= r_acc ^ in_data;
                        r_cnt <= r_cnt - 6'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    router_wr_hold_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_PORTS  (NUM_PORTS)
    ) u_hold (
        .write_clk   (write_clk),
        .reset       (reset),
        .i_load      (w_accept),
        .i_data      (in_data),
        .i_dest      (w_byte_dest),
        .i_drop      (w_byte_drop),
        .i_fifo_full (fifo_full),
        .o_ready     (in_ready),
        .o_wr_fire   (w_wr_fire),
        .o_wr_data   (fifo_wr_data),
        .o_write_inc (fifo_write_inc)
    );

`ifdef ROUTER_WR_STATS_EN
    always_ff @(posedge write_clk or posedge reset) begin
        if (reset) begin
            pkt_cnt  <= '0;
            err_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (pkt_done && (pkt_cnt != '1)) begin
                pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
            end
            if (parity_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_WIDTH'(1);
            end
            if (pkt_drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_WIDTH'(1);
            end
        end
    end
`endif

endmodule
